zrb_sd_cmd_framer: RTL and testbench

//  Upstream of the SPI byte engine (zrb_spi_rxtx). Turns one SD command request (index + 32-bit arg) into a 6-byte SPI frame.

---
 rtl/zrb_sd_cmd_framer_pkg.sv | 36 +++
 rtl/zrb_sd_cmd_framer_if.sv | 28 ++
 rtl/zrb_sd_cmd_framer_crc7.sv | 24 ++
 rtl/zrb_sd_cmd_framer.sv | 140 ++++++++++++++
 tb/tb_zrb_sd_cmd_framer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zrb_sd_cmd_framer_pkg.sv
// Shared definitions for the SD command framer: FSM encoding, SD command indices,
// CRC7 polynomial, fixed CRC bytes used when CRC generation is compiled out, R1 bits.
package zrb_sd_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEND    = 3'd1;
  localparam logic [2:0] ST_ECHO    = 3'd2;
  localparam logic [2:0] ST_POLL_TX = 3'd3;
  localparam logic [2:0] ST_POLL_RX = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_SEND    = ST_SEND,
    S_ECHO    = ST_ECHO,
    S_POLL_TX = ST_POLL_TX,
    S_POLL_RX = ST_POLL_RX,
    S_DONE    = ST_DONE
  } state_e;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  // Only CMD0 and CMD8 are CRC-checked by a card still in SPI mode.
  localparam logic [7:0] CMD0_CRC_BYTE = 8'h95;
  localparam logic [7:0] CMD8_CRC_BYTE = 8'h87;

  localparam int R1_IDLE_BIT        = 0;
  localparam int R1_ILLEGAL_CMD_BIT = 2;

endpackage

// File: rtl/zrb_sd_cmd_framer_if.sv
// Bus bundle for zrb_sd_cmd_framer: command request, SPI engine FIFO handshakes, R1 response.
// slave is the framer's view; master is the view of whatever surrounds it.
interface zrb_sd_cmd_framer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rsp_valid;
  logic [7:0]  rsp_r1;
  logic        rsp_timeout;
  logic        busy;

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg, tx_ready, rx_valid, rx_data,
    output cmd_ready, tx_valid, tx_data, rx_ready, rsp_valid, rsp_r1, rsp_timeout, busy
  );

  modport master (
    output cmd_valid, cmd_index, cmd_arg, tx_ready, rx_valid, rx_data,
    input  cmd_ready, tx_valid, tx_data, rx_ready, rsp_valid, rsp_r1, rsp_timeout, busy
  );
endinterface

// File: rtl/zrb_sd_cmd_framer_crc7.sv
// Byte-wide CRC7 update (x^7+x^3+1, init 0, MSB first) for the SD command frame.
// Only compiled when ZRB_SD_CMD_CRC_EN is defined.
`ifdef ZRB_SD_CMD_CRC_EN
module zrb_crc7
  import zrb_sd_pkg::*;
(
  input  logic [6:0] crc_i,
  input  logic [7:0] byte_i,
  output logic [6:0] crc_o
);
  logic [6:0] crc;
  logic       fb;

  always_comb begin
    crc = crc_i;
    fb  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb  = crc[6] ^ byte_i[i];
      crc = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
    crc_o = crc;
  end
endmodule
`endif

// File: rtl/zrb_sd_cmd_framer.sv
// SD command framer: frames index+arg into 6 SPI bytes, drops echoes, polls for R1.
// Build option: define ZRB_SD_CMD_CRC_EN to compute a real CRC7 for the last frame byte.
module zrb_sd_cmd_framer
  import zrb_sd_pkg::*;
#(
  parameter int unsigned POLL_MAX  = 8,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input logic                clk,
  input logic                reset_n,
  zrb_sd_cmd_framer_if.slave bus
);
  localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);

  state_e          state_q;
  logic [5:0][7:0] frame_q;
  logic [2:0]      byteCnt_q;
  logic [7:0]      pollCnt_q;
  logic [7:0]      txData_q;
  logic            txValid_q;
  logic            rspValid_q;
  logic [7:0]      rspR1_q;
  logic            rspTimeout_q;
  logic            busy_q;
  logic            drainEn_q;

  logic [4:0][7:0] hdrBytes;
  logic [5:0][7:0] frameNew;
  logic [7:0]      crcByte;
  logic            txFire;
  logic            rxPop;

  assign hdrBytes = {bus.cmd_arg[7:0], bus.cmd_arg[15:8], bus.cmd_arg[23:16],
                     bus.cmd_arg[31:24], 2'b01, bus.cmd_index};
  assign frameNew = {crcByte, hdrBytes};

`ifdef ZRB_SD_CMD_CRC_EN
  logic [6:0] crcChain [6];
  assign crcChain[0] = 7'h00;
  for (genvar i = 0; i < 5; i++) begin : gCrc
    zrb_crc7 uCrc (.crc_i(crcChain[i]), .byte_i(hdrBytes[i]), .crc_o(crcChain[i+1]));
  end
  assign crcByte = {crcChain[5], 1'b1};
`else
  always_comb begin
    case (bus.cmd_index)
      CMD0:    crcByte = CMD0_CRC_BYTE;
      CMD8:    crcByte = CMD8_CRC_BYTE;
      default: crcByte = 8'hFF;
    endcase
  end
`endif

  // drainEn_q keeps the idle-time drain of stray rx bytes off until a cycle after reset.
  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.tx_valid    = txValid_q;
  assign bus.tx_data     = txData_q;
  assign bus.rx_ready    = bus.rx_valid & ((state_q == S_ECHO) || (state_q == S_POLL_RX) ||
                                           ((state_q == S_IDLE) && drainEn_q));
  assign bus.rsp_valid   = rspValid_q;
  assign bus.rsp_r1      = rspR1_q;
  assign bus.rsp_timeout = rspTimeout_q;
  assign bus.busy        = busy_q;

  assign txFire = txValid_q & bus.tx_ready;
  assign rxPop  = bus.rx_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      frame_q      <= '0;
      byteCnt_q    <= '0;
      pollCnt_q    <= '0;
      txData_q     <= '0;
      txValid_q    <= 1'b0;
      rspValid_q   <= 1'b0;
      rspR1_q      <= 8'hFF;
      rspTimeout_q <= 1'b0;
      busy_q       <= 1'b0;
      drainEn_q    <= 1'b0;
    end else begin
      drainEn_q  <= 1'b1;
      rspValid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.cmd_valid) begin
          frame_q   <= frameNew;
          txData_q  <= frameNew[0];
          byteCnt_q <= '0;
          txValid_q <= 1'b1;
          busy_q    <= 1'b1;
          state_q   <= S_SEND;
        end
        S_SEND: if (txFire) begin
          txValid_q <= 1'b0;
          frame_q   <= {8'h00, frame_q[5:1]};
          state_q   <= S_ECHO;
        end
        // Lockstep: the next byte goes out only once the echo of the last one is popped.
        S_ECHO: if (rxPop) begin
          txValid_q <= 1'b1;
          if (byteCnt_q == 3'd5) begin
            pollCnt_q <= '0;
            txData_q  <= FILL_BYTE;
            state_q   <= S_POLL_TX;
          end else begin
            byteCnt_q <= byteCnt_q + 3'd1;
            txData_q  <= frame_q[0];
            state_q   <= S_SEND;
          end
        end
        S_POLL_TX: if (txFire) begin
          pollCnt_q <= pollCnt_q + 8'd1;
          txValid_q <= 1'b0;
          state_q   <= S_POLL_RX;
        end
        S_POLL_RX: if (rxPop) begin
          if (!bus.rx_data[7]) begin
            rspR1_q      <= bus.rx_data;
            rspTimeout_q <= 1'b0;
            rspValid_q   <= 1'b1;
            state_q      <= S_DONE;
          end else if (pollCnt_q == POLL_LIMIT) begin
            rspR1_q      <= 8'hFF;
            rspTimeout_q <= 1'b1;
            rspValid_q   <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            txValid_q <= 1'b1;
            state_q   <= S_POLL_TX;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_zrb_sd_cmd_framer.sv
// Self-checking bench for zrb_sd_cmd_framer: the SPI engine is a loop-back FIFO pair
// with scripted poll replies and random tx_ready stalls; expectations come from a frame model.
module tb_zrb_sd_cmd_framer;
  import zrb_sd_pkg::*;

  localparam int         POLL_MAX = 8;
  localparam logic [7:0] FILL     = 8'hFF;
  localparam int         BUDGET   = 600;

`ifdef ZRB_SD_CMD_CRC_EN
  localparam logic [7:0] B5_CMD17  = 8'h55;
  localparam logic [7:0] B5_CMD55  = 8'h65;
  localparam logic [7:0] B5_ACMD41 = 8'h77;
`else
  localparam logic [7:0] B5_CMD17  = 8'hFF;
  localparam logic [7:0] B5_CMD55  = 8'hFF;
  localparam logic [7:0] B5_ACMD41 = 8'hFF;
`endif

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  r1Byte;
    int          respPoll;
    logic [7:0]  expB5;
    logic [7:0]  expR1;
    logic        expTo;
    int          expPolls;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  zrb_sd_cmd_framer_if busIf ();

  zrb_sd_cmd_framer #(.POLL_MAX(POLL_MAX), .FILL_BYTE(FILL)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(busIf)
  );

  int nVec = 0;
  int nMiss = 0;
  logic [7:0] txLog[$];
  logic [7:0] rxQ[$];
  logic [7:0] pollBytes[$];
  logic cmdReq = 1'b0;
  logic holdCmd = 1'b0;
  int stallPct = 0;
  int stallLeft = 0;
  logic [7:0] stallExp = 8'h00;
  int accepts, bothHigh;
  logic sRspValid, sCmdReady, sTo, sBusy;
  logic [7:0] sR1;
  logic finished, rspAfter, readyAfter, busyAtPulse, gotTo;
  logic [7:0] gotR1, r1After;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] modelB5(input logic [5:0] idx, input logic [31:0] arg);
`ifdef ZRB_SD_CMD_CRC_EN
    logic [46:0] m;
    m = {2'b01, idx, arg, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
    return {m[6:0], 1'b1};
`else
    if (idx == 6'd0) return 8'h95;
    if (idx == 6'd8) return 8'h87;
    return 8'hFF;
`endif
  endfunction

  function automatic logic [7:0] modelFrameByte(input logic [5:0] idx, input logic [31:0] arg, input int n);
    logic [31:0] sh;
    if (n == 0) return {2'b01, idx};
    if (n == 5) return modelB5(idx, arg);
    sh = arg >> (8 * (4 - n));
    return sh[7:0];
  endfunction

  function automatic logic [7:0] pollReply(input int k);
    return (k <= pollBytes.size()) ? pollBytes[k-1] : 8'hFF;
  endfunction

  task automatic modelResponse(output logic [7:0] r1, output logic to, output int polls);
    logic [7:0] b;
    logic found;
    r1 = 8'hFF; to = 1'b1; polls = POLL_MAX; found = 1'b0;
    for (int k = 1; k <= POLL_MAX; k++) begin
      b = pollReply(k);
      if (!found && !b[7]) begin
        found = 1'b1; r1 = b; to = 1'b0; polls = k;
      end
    end
  endtask

  // One clock of the SPI engine model: drive at negedge, sample, then update queues after posedge.
  task automatic cycle();
    logic txFire, rxFire, acc, stallNow;
    logic [7:0] txByte;
    int k;
    @(negedge clk);
    stallNow = 1'b0;
    busIf.cmd_valid = cmdReq;
    if (stallLeft > 0 && txLog.size() == 2 && busIf.tx_valid) begin
      stallNow = 1'b1;
      stallLeft--;
      busIf.tx_ready = 1'b0;
    end else begin
      busIf.tx_ready = ($urandom_range(99) >= stallPct);
    end
    if (rxQ.size() > 0) begin
      busIf.rx_valid = 1'b1; busIf.rx_data = rxQ[0];
    end else begin
      busIf.rx_valid = 1'b0; busIf.rx_data = 8'h00;
    end
    #2;
    sRspValid = busIf.rsp_valid; sCmdReady = busIf.cmd_ready;
    sR1 = busIf.rsp_r1; sTo = busIf.rsp_timeout; sBusy = busIf.busy;
    txFire = busIf.tx_valid & busIf.tx_ready;
    txByte = busIf.tx_data;
    rxFire = busIf.rx_valid & busIf.rx_ready;
    acc = busIf.cmd_valid & busIf.cmd_ready;
    if (busIf.tx_valid & busIf.rx_ready) bothHigh++;
    if (stallNow) checkOutput("B2 held during stall", 32'(busIf.tx_data), 32'(stallExp));
    @(posedge clk);
    #1;
    if (acc) begin
      accepts++;
      if (!holdCmd) cmdReq = 1'b0;
    end
    if (rxFire) void'(rxQ.pop_front());
    if (txFire) begin
      txLog.push_back(txByte);
      if (txLog.size() <= 6) rxQ.push_back(txByte);
      else begin
        k = txLog.size() - 6;
        rxQ.push_back(pollReply(k));
      end
    end
  endtask

  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg,
                               input logic [7:0] r1Byte, input int respPoll, input logic noisy);
    int n;
    logic afterPulse;
    pollBytes.delete();
    for (int k = 1; k <= 12; k++)
      pollBytes.push_back((k == respPoll) ? r1Byte :
                          (noisy ? (8'h80 | 8'($urandom_range(255))) : 8'hFF));
    txLog.delete();
    accepts = 0; bothHigh = 0;
    busIf.cmd_index = idx; busIf.cmd_arg = arg;
    cmdReq = 1'b1;
    finished = 1'b0; afterPulse = 1'b0; n = 0;
    while (!finished && n < BUDGET) begin
      cycle();
      n++;
      if (afterPulse) begin
        rspAfter = sRspValid; readyAfter = sCmdReady; r1After = sR1;
        finished = 1'b1;
      end else if (sRspValid) begin
        gotR1 = sR1; gotTo = sTo; busyAtPulse = sBusy;
        afterPulse = 1'b1;
        cmdReq = 1'b0;
      end
    end
    cmdReq = 1'b0;
  endtask

  task automatic checkCommand(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] expB5,
                              input logic [7:0] expR1, input logic expTo, input int expPolls);
    logic [7:0] e;
    checkOutput($sformatf("cmd%0d finished within budget", idx), 32'(finished), 32'd1);
    checkOutput($sformatf("cmd%0d tx byte count", idx), 32'(txLog.size()), 32'(6 + expPolls));
    for (int i = 0; i < txLog.size(); i++) begin
      e = (i < 5) ? modelFrameByte(idx, arg, i) : ((i == 5) ? expB5 : FILL);
      checkOutput($sformatf("cmd%0d tx byte %0d", idx, i), 32'(txLog[i]), 32'(e));
    end
    checkOutput($sformatf("cmd%0d rsp_r1", idx), 32'(gotR1), 32'(expR1));
    checkOutput($sformatf("cmd%0d rsp_timeout", idx), 32'(gotTo), 32'(expTo));
    checkOutput($sformatf("cmd%0d busy at pulse", idx), 32'(busyAtPulse), 32'd1);
    checkOutput($sformatf("cmd%0d rsp_valid one cycle", idx), 32'(rspAfter), 32'd0);
    checkOutput($sformatf("cmd%0d cmd_ready after pulse", idx), 32'(readyAfter), 32'd1);
    checkOutput($sformatf("cmd%0d rsp_r1 held", idx), 32'(r1After), 32'(expR1));
    checkOutput($sformatf("cmd%0d accept count", idx), 32'(accepts), 32'd1);
    checkOutput($sformatf("cmd%0d tx_valid with rx_ready", idx), 32'(bothHigh), 32'd0);
  endtask

  initial begin
    vec_t tbl[7];
    logic [5:0] rIdx;
    logic [31:0] rArg;
    logic [7:0] rR1, eR1;
    logic eTo;
    int rPoll, eP, n;

    busIf.cmd_valid = 1'b0; busIf.cmd_index = '0; busIf.cmd_arg = '0;
    busIf.tx_ready = 1'b0; busIf.rx_data = 8'h00;
    busIf.rx_valid = 1'b1;

    repeat (2) @(negedge clk);
    #2;
    checkOutput("reset cmd_ready", 32'(busIf.cmd_ready), 32'd1);
    checkOutput("reset tx_valid", 32'(busIf.tx_valid), 32'd0);
    checkOutput("reset rx_ready", 32'(busIf.rx_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(busIf.rsp_valid), 32'd0);
    checkOutput("reset rsp_r1", 32'(busIf.rsp_r1), 32'hFF);
    checkOutput("reset rsp_timeout", 32'(busIf.rsp_timeout), 32'd0);
    checkOutput("reset busy", 32'(busIf.busy), 32'd0);
    busIf.rx_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    tbl[0] = '{CMD0,   32'h0000_0000, 8'h01, 2, 8'h95,     8'h01, 1'b0, 2};
    tbl[1] = '{CMD8,   32'h0000_01AA, 8'h01, 1, 8'h87,     8'h01, 1'b0, 1};
    tbl[2] = '{CMD17,  32'h0000_0000, 8'h00, 4, B5_CMD17,  8'h00, 1'b0, 4};
    tbl[3] = '{CMD55,  32'h0000_0000, 8'h01, 0, B5_CMD55,  8'hFF, 1'b1, 8};
    tbl[4] = '{ACMD41, 32'h4000_0000, 8'h05, 1, B5_ACMD41, 8'h05, 1'b0, 1};
    tbl[5] = '{CMD0,   32'h0000_0000, 8'h00, 8, 8'h95,     8'h00, 1'b0, 8};
    tbl[6] = '{CMD8,   32'h0000_01AA, 8'h01, 9, 8'h87,     8'hFF, 1'b1, 8};

    for (int i = 0; i < 7; i++) begin
      stallPct = (i % 2) * 25;
      applyStimulus(tbl[i].idx, tbl[i].arg, tbl[i].r1Byte, tbl[i].respPoll, 1'b0);
      checkCommand(tbl[i].idx, tbl[i].arg, tbl[i].expB5, tbl[i].expR1, tbl[i].expTo, tbl[i].expPolls);
    end

    // cmd_valid held high across the whole command, including DONE.
    holdCmd = 1'b1;
    applyStimulus(tbl[0].idx, tbl[0].arg, tbl[0].r1Byte, tbl[0].respPoll, 1'b0);
    checkCommand(tbl[0].idx, tbl[0].arg, tbl[0].expB5, tbl[0].expR1, tbl[0].expTo, tbl[0].expPolls);
    holdCmd = 1'b0;

    // tx_ready forced low for 5 cycles while B2 is offered.
    stallPct = 0;
    stallLeft = 5;
    stallExp = modelFrameByte(CMD17, 32'h0012_3400, 2);
    applyStimulus(CMD17, 32'h0012_3400, 8'h00, 3, 1'b0);
    checkCommand(CMD17, 32'h0012_3400, modelB5(CMD17, 32'h0012_3400), 8'h00, 1'b0, 3);
    checkOutput("stall cycles consumed", 32'(stallLeft), 32'd0);

    for (int r = 0; r < 20; r++) begin
      rIdx = 6'($urandom_range(63));
      rArg = $urandom;
      rR1 = 8'($urandom_range(127));
      rPoll = $urandom_range(0, 10);
      stallPct = $urandom_range(0, 40);
      applyStimulus(rIdx, rArg, rR1, rPoll, 1'b1);
      modelResponse(eR1, eTo, eP);
      checkCommand(rIdx, rArg, modelB5(rIdx, rArg), eR1, eTo, eP);
    end

    // Reset pulsed while the framer waits for the echo of B3.
    stallPct = 0;
    applyStimulus(tbl[4].idx, tbl[4].arg, tbl[4].r1Byte, tbl[4].respPoll, 1'b0);
    checkCommand(tbl[4].idx, tbl[4].arg, tbl[4].expB5, tbl[4].expR1, tbl[4].expTo, tbl[4].expPolls);
    txLog.delete();
    busIf.cmd_index = CMD17; busIf.cmd_arg = 32'hDEAD_BEEF;
    cmdReq = 1'b1;
    n = 0;
    while (txLog.size() < 4 && n < BUDGET) begin
      cycle();
      n++;
    end
    checkOutput("reached B3 echo", 32'(txLog.size()), 32'd4);
    @(negedge clk);
    reset_n = 1'b0;
    cmdReq = 1'b0; busIf.cmd_valid = 1'b0; busIf.tx_ready = 1'b1;
    busIf.rx_valid = (rxQ.size() > 0);
    busIf.rx_data = (rxQ.size() > 0) ? rxQ[0] : 8'h00;
    #2;
    checkOutput("mid-frame reset tx_valid", 32'(busIf.tx_valid), 32'd0);
    checkOutput("mid-frame reset rx_ready", 32'(busIf.rx_ready), 32'd0);
    checkOutput("mid-frame reset rsp_valid", 32'(busIf.rsp_valid), 32'd0);
    checkOutput("mid-frame reset rsp_r1", 32'(busIf.rsp_r1), 32'hFF);
    checkOutput("mid-frame reset rsp_timeout", 32'(busIf.rsp_timeout), 32'd0);
    checkOutput("mid-frame reset busy", 32'(busIf.busy), 32'd0);
    checkOutput("mid-frame reset cmd_ready", 32'(busIf.cmd_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) cycle();
    checkOutput("stray echo drained", 32'(rxQ.size()), 32'd0);
    applyStimulus(tbl[0].idx, tbl[0].arg, tbl[0].r1Byte, tbl[0].respPoll, 1'b0);
    checkCommand(tbl[0].idx, tbl[0].arg, tbl[0].expB5, tbl[0].expR1, tbl[0].expTo, tbl[0].expPolls);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end
endmodule
